// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//   Serialises one parallel byte per request into an asynchronous UART frame
//   (start bit, DATA_BITS payload bits LSB first, optional parity bit,
//   STOP_BITS stop bits) on tx_out. Bit timing comes entirely from the
//   external tx_baud_tick pulse (one pulse per bit period); there is no
//   internal divider, so every bit lasts exactly one tick interval.
//
// Configuration macro:
//   UART_TX_PARITY_EN - when defined, a parity bit follows the data bits and
//                       its sense is set by PARITY_ODD (0 = even, 1 = odd).
//                       When undefined there is no parity state or logic and
//                       PARITY_ODD has no effect.
//
// Parameters:
//   DATA_BITS   payload bits per frame, legal 5..9
//   STOP_BITS   stop bits per frame, legal 1 or 2
//   PARITY_ODD  parity sense when parity is enabled
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   tx_baud_tick  in   one-clock pulse per bit period
//   tx_start      in   send request, only sampled while tx_busy is low
//   tx_data       in   payload, captured on the accepting edge
//   tx_out        out  serial line, idles high
//   tx_busy       out  high from the cycle after acceptance until frame end
//   tx_done       out  one-clock pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // The bit counter is sized for the data phase and reused to count stop
  // bits, which never need more than the data-phase width.
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  // Reject illegal parameter combinations at elaboration time rather than
  // letting a malformed frame reach the pad.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_transmitter: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParitySense
    $error("uart_transmitter: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic PARITY_SENSE = 1'(PARITY_ODD);
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;
`endif

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CW-1:0]        bitCnt_q;
  logic                 txOut_q;
  logic                 txBusy_q;
  logic                 txDone_q;
`ifdef UART_TX_PARITY_EN
  // Untouched copy of the accepted byte; the shift register is consumed
  // during the data phase, so parity is computed from this instead.
  logic [DATA_BITS-1:0] data_q;
`endif

  // Frame sequencer with every output registered. Each state presents the
  // line value for the bit currently on the wire and moves on only when a
  // baud tick arrives, so bit boundaries always land on the tick grid.
  // SYNC exists because acceptance can happen anywhere inside a tick
  // interval; waiting for the next tick before dropping the line gives a
  // full-width start bit. A tick in IDLE (including one that coincides with
  // tx_start) is deliberately not consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      txOut_q  <= 1'b1;
      txBusy_q <= 1'b0;
      txDone_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q   <= '0;
`endif
    end else begin
      txDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txOut_q <= 1'b1;
          if (tx_start) begin
            shift_q  <= tx_data;
`ifdef UART_TX_PARITY_EN
            data_q   <= tx_data;
`endif
            bitCnt_q <= '0;
            txBusy_q <= 1'b1;
            state_q  <= SYNC;
          end
        end

        SYNC: begin
          if (tx_baud_tick) begin
            txOut_q <= 1'b0;
            state_q <= START;
          end
        end

        START: begin
          if (tx_baud_tick) begin
            txOut_q <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end

        // bitCnt_q counts data bits already completed; the tick that ends
        // the last one hands over to parity or straight to the stop phase.
        DATA: begin
          if (tx_baud_tick) begin
            if (bitCnt_q == LAST_DATA) begin
              bitCnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              txOut_q  <= (^data_q) ^ PARITY_SENSE;
              state_q  <= PARITY;
`else
              txOut_q  <= 1'b1;
              state_q  <= STOP;
`endif
            end else begin
              bitCnt_q <= bitCnt_q + CW'(1);
              txOut_q  <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tx_baud_tick) begin
            txOut_q <= 1'b1;
            state_q <= STOP;
          end
        end
`endif

        STOP: begin
          txOut_q <= 1'b1;
          if (tx_baud_tick) begin
            if (bitCnt_q == LAST_STOP) begin
              bitCnt_q <= '0;
              txBusy_q <= 1'b0;
              txDone_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              bitCnt_q <= bitCnt_q + CW'(1);
            end
          end
        end

        default: begin
          txOut_q  <= 1'b1;
          txBusy_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign tx_out  = txOut_q;
  assign tx_busy = txBusy_q;
  assign tx_done = txDone_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Drives uart_transmitter with a free-running, randomly spaced baud tick and
// a sequence of directed and random byte requests. A queue-based frame model
// predicts tx_out / tx_busy / tx_done every clock, and a capture task decodes
// the line one value per tick so whole frames can be checked against
// hand-written bit patterns. Honours UART_TX_PARITY_EN like the design.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int FRAME_TICKS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;
  localparam int CYCLE_LIMIT = 2000;

  logic                 clk     = 1'b0;
  logic                 rst     = 1'b1;
  logic                 tick    = 1'b0;
  logic                 txStart = 1'b0;
  logic [DATA_BITS-1:0] txData  = '0;
  logic                 txOut;
  logic                 txBusy;
  logic                 txDone;

  int   checkCount = 0;
  int   passCount  = 0;
  int   doneCount  = 0;
  bit   compareOn  = 1'b0;
  logic tickSeen   = 1'b0;
  int   tickGap    = 0;

  // 50 MHz system clock.
  always #10 clk = ~clk;

  uart_transmitter #(
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_baud_tick(tick),
    .tx_start    (txStart),
    .tx_data     (txData),
    .tx_out      (txOut),
    .tx_busy     (txBusy),
    .tx_done     (txDone)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Baud tick stand-in: one-clock pulses with a random 3..7 clock spacing,
  // so the design sees an irregular but always legal tick grid.
  initial begin
    forever begin
      @(negedge clk);
      if (tickGap == 0) begin
        tick    = 1'b1;
        tickGap = $urandom_range(6, 2);
      end else begin
        tick = 1'b0;
        tickGap--;
      end
    end
  end

  // Remembers whether the most recent rising edge carried a tick.
  always @(posedge clk) tickSeen <= tick;

  // Frame model: an accepted byte becomes a queue of line values, one per
  // tick. Every tick while busy pops the next value onto the line; the tick
  // that finds the queue empty ends the frame with a done pulse.
  logic expLine = 1'b1;
  logic expBusy = 1'b0;
  logic expDone = 1'b0;
  bit   bitQ[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expLine = 1'b1;
      expBusy = 1'b0;
      expDone = 1'b0;
      bitQ.delete();
    end else begin
      expDone = 1'b0;
      if (!expBusy) begin
        if (txStart) begin
          expBusy = 1'b1;
          bitQ.push_back(1'b0);
          for (int i = 0; i < DATA_BITS; i++) bitQ.push_back(txData[i]);
`ifdef UART_TX_PARITY_EN
          bitQ.push_back((^txData) ^ 1'(PARITY_ODD));
`endif
          for (int i = 0; i < STOP_BITS; i++) bitQ.push_back(1'b1);
        end
      end else if (tick) begin
        if (bitQ.size() > 0) begin
          expLine = bitQ.pop_front();
        end else begin
          expLine = 1'b1;
          expBusy = 1'b0;
          expDone = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the design against the model.
  always @(negedge clk) begin
    if (compareOn && !rst) begin
      checkOutput("tx_out", int'(txOut), int'(expLine));
      checkOutput("tx_busy", int'(txBusy), int'(expBusy));
      checkOutput("tx_done", int'(txDone), int'(expDone));
      if (txDone) doneCount++;
    end
  end

  // Waits for the frame to be accepted, optionally drops tx_start and
  // presents the next byte, then records the line value after every tick
  // until tx_done. Entry 0 is the start bit; the final entry is the idle
  // level seen on the tick that ends the frame.
  task automatic applyStimulus(input bit dropStart, input logic [DATA_BITS-1:0] nextData,
                               output int nTicks, output logic [DATA_BITS-1:0] rxByte,
                               output logic [15:0] lineBits);
    int budget = 0;
    nTicks   = 0;
    lineBits = '1;
    rxByte   = '0;
    while (!txBusy && budget < CYCLE_LIMIT) begin
      @(negedge clk);
      budget++;
    end
    if (dropStart) txStart = 1'b0;
    txData = nextData;
    while (!txDone && budget < CYCLE_LIMIT) begin
      @(negedge clk);
      budget++;
      if (tickSeen && (txBusy || txDone)) begin
        if (nTicks < 16) lineBits[nTicks] = txOut;
        nTicks++;
      end
    end
    checkOutput("frame finished within cycle budget", int'(budget < CYCLE_LIMIT), 1);
    for (int i = 0; i < DATA_BITS; i++) rxByte[i] = lineBits[1 + i];
  endtask

  initial begin
    logic [DATA_BITS-1:0] rxByte;
    logic [DATA_BITS-1:0] randData;
    logic [15:0]          bits;
    logic                 expSeq [FRAME_TICKS];
    int                   nTicks;
    int                   doneBefore;
    int                   seen;
    int                   budget;

    // Reset held for five clocks with ticks running.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset tx_out", int'(txOut), 1);
    checkOutput("reset tx_busy", int'(txBusy), 0);
    checkOutput("reset tx_done", int'(txDone), 0);
    #3 rst = 1'b0;
    compareOn = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("idle tx_out", int'(txOut), 1);
    checkOutput("idle tx_busy", int'(txBusy), 0);
    checkOutput("idle no tx_done", doneCount, 0);

    // 0xA5: start, 1,0,1,0,0,1,0,1 LSB first, [parity], stop.
`ifdef UART_TX_PARITY_EN
    expSeq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    expSeq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    doneBefore = doneCount;
    txData  = 8'hA5;
    txStart = 1'b1;
    applyStimulus(1'b1, 8'hA5, nTicks, rxByte, bits);
    for (int i = 0; i < FRAME_TICKS; i++)
      checkOutput($sformatf("0xA5 line bit %0d", i), int'(bits[i]), int'(expSeq[i]));
    checkOutput("0xA5 ticks incl. sync", nTicks, FRAME_TICKS + 1);
    checkOutput("0xA5 decoded byte", int'(rxByte), 'hA5);
    @(negedge clk);
    checkOutput("0xA5 single tx_done", doneCount - doneBefore, 1);

    // Back-to-back: tx_start stays high so the second byte is taken in the
    // tx_done cycle; the sync tick is then the only idle interval.
    repeat (5) @(negedge clk);
    doneBefore = doneCount;
    txData  = 8'hB4;
    txStart = 1'b1;
    applyStimulus(1'b0, 8'h3C, nTicks, rxByte, bits);
    checkOutput("b2b first byte", int'(rxByte), 'hB4);
    applyStimulus(1'b1, 8'h3C, nTicks, rxByte, bits);
    checkOutput("b2b second byte", int'(rxByte), 'h3C);
    checkOutput("b2b second start after one idle tick", int'(bits[0]), 0);
    checkOutput("b2b second frame ticks", nTicks, FRAME_TICKS + 1);
    @(negedge clk);
    checkOutput("b2b two tx_done pulses", doneCount - doneBefore, 2);

    // A request for 0xFF in the middle of a 0x00 frame is dropped.
    repeat (3) @(negedge clk);
    doneBefore = doneCount;
    txData  = 8'h00;
    txStart = 1'b1;
    fork
      applyStimulus(1'b1, 8'h00, nTicks, rxByte, bits);
      begin
        repeat (10) @(negedge clk);
        txData  = 8'hFF;
        txStart = 1'b1;
        repeat (6) @(negedge clk);
        txStart = 1'b0;
      end
    join
    checkOutput("busy request ignored, byte", int'(rxByte), 'h00);
    repeat (30) @(negedge clk);
    checkOutput("busy request ignored, single tx_done", doneCount - doneBefore, 1);
    checkOutput("busy request not queued", int'(txBusy), 0);

    // Reset while data bit 3 of 0xF0 (a zero) is on the line.
    doneBefore = doneCount;
    txData  = 8'hF0;
    txStart = 1'b1;
    budget  = 0;
    while (!txBusy && budget < CYCLE_LIMIT) begin
      @(negedge clk);
      budget++;
    end
    txStart = 1'b0;
    seen = 0;
    while (seen < 5 && budget < CYCLE_LIMIT) begin
      @(negedge clk);
      budget++;
      if (tickSeen) seen++;
    end
    checkOutput("data bit 3 reached", int'(budget < CYCLE_LIMIT), 1);
    checkOutput("data bit 3 low before reset", int'(txOut), 0);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset tx_out high", int'(txOut), 1);
    checkOutput("async reset tx_busy low", int'(txBusy), 0);
    checkOutput("async reset no tx_done", int'(txDone), 0);
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("aborted frame gives no tx_done", doneCount - doneBefore, 0);
    txData  = 8'h5A;
    txStart = 1'b1;
    applyStimulus(1'b1, 8'h5A, nTicks, rxByte, bits);
    checkOutput("after abort byte", int'(rxByte), 'h5A);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so even parity sends a one.
    repeat (2) @(negedge clk);
    txData  = 8'h07;
    txStart = 1'b1;
    applyStimulus(1'b1, 8'h07, nTicks, rxByte, bits);
    checkOutput("0x07 parity bit", int'(bits[1 + DATA_BITS]), 1);
`endif

    // Random bytes with random idle gaps; some requests land on a tick.
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(8, 0)) @(negedge clk);
      randData = DATA_BITS'($urandom);
      txData   = randData;
      txStart  = 1'b1;
      applyStimulus(1'b1, randData, nTicks, rxByte, bits);
      checkOutput($sformatf("random frame %0d byte", n), int'(rxByte), int'(randData));
      checkOutput($sformatf("random frame %0d ticks", n), nTicks, FRAME_TICKS + 1);
    end

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Safety net so a stuck design cannot hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
